// File: rtl/syn_update_sequencer_if.sv
// Control bundle between the training sequencer and the synaptic core.
// The sequencer drives the SRAM controls and neuron addresses; the upstream side drives IS_TRAIN/START.
interface syn_update_sequencer_if #(
    parameter int PRE_NEUR_ADDR_WIDTH  = 10,
    parameter int POST_NEUR_ADDR_WIDTH = 10,
    parameter int SYN_ARRAY_ADDR_WIDTH = 16
);
    logic                            IS_TRAIN;
    logic                            START;
    logic                            BUSY;
    logic                            DONE;
    logic                            CTRL_SYNARRAY_CS;
    logic                            CTRL_SYNARRAY_WE;
    logic                            CTRL_GRAD_ARRAY_CS;
    logic                            CTRL_GRAD_ARRAY_WE;
    logic [SYN_ARRAY_ADDR_WIDTH-1:0] CTRL_SYNARRAY_ADDR;
    logic [PRE_NEUR_ADDR_WIDTH-1:0]  CTRL_PRE_NEUR_ADDR;
    logic [POST_NEUR_ADDR_WIDTH-1:0] CTRL_POST_NEURON_ADDRESS;

    modport master (
        output IS_TRAIN, START,
        input  BUSY, DONE, CTRL_SYNARRAY_CS, CTRL_SYNARRAY_WE, CTRL_GRAD_ARRAY_CS,
               CTRL_GRAD_ARRAY_WE, CTRL_SYNARRAY_ADDR, CTRL_PRE_NEUR_ADDR, CTRL_POST_NEURON_ADDRESS
    );

    modport slave (
        input  IS_TRAIN, START,
        output BUSY, DONE, CTRL_SYNARRAY_CS, CTRL_SYNARRAY_WE, CTRL_GRAD_ARRAY_CS,
               CTRL_GRAD_ARRAY_WE, CTRL_SYNARRAY_ADDR, CTRL_PRE_NEUR_ADDR, CTRL_POST_NEURON_ADDRESS
    );
endinterface

// File: rtl/syn_update_sequencer.sv
// Post-sample sweep controller: walks every synaptic word once as RD, optional WAIT, WR,
// driving weight/gradient SRAM controls and the pre/post neuron addresses for the STDP lanes.
module syn_update_sequencer #(
    parameter int INPUT_NEURON         = 784,
    parameter int OUTPUT_NEURON        = 256,
    parameter int POST_NEUR_PARALLEL   = 4,
    parameter int PRE_NEUR_ADDR_WIDTH  = 10,
    parameter int POST_NEUR_ADDR_WIDTH = 10,
    parameter int SYN_ARRAY_ADDR_WIDTH = 16,
    parameter int UPDATE_LATENCY       = 0
) (
    input logic                 CLK,
    input logic                 RSTN,
    syn_update_sequencer_if.slave bus
);
    localparam int GROUPS = OUTPUT_NEURON / POST_NEUR_PARALLEL;
    localparam int DEPTH  = INPUT_NEURON * GROUPS;

    localparam logic [SYN_ARRAY_ADDR_WIDTH-1:0] LAST_ADDR = SYN_ARRAY_ADDR_WIDTH'(DEPTH - 1);
    localparam logic [SYN_ARRAY_ADDR_WIDTH-1:0] ADDR_ONE  = SYN_ARRAY_ADDR_WIDTH'(1'b1);
    localparam logic [PRE_NEUR_ADDR_WIDTH-1:0]  PRE_ONE   = PRE_NEUR_ADDR_WIDTH'(1'b1);
    localparam logic [POST_NEUR_ADDR_WIDTH-1:0] POST_STEP = POST_NEUR_ADDR_WIDTH'(POST_NEUR_PARALLEL);
    localparam logic [POST_NEUR_ADDR_WIDTH-1:0] POST_LAST = POST_NEUR_ADDR_WIDTH'(OUTPUT_NEURON - POST_NEUR_PARALLEL);
    localparam logic [2:0] WAIT_LAST = (UPDATE_LATENCY > 0) ? 3'(UPDATE_LATENCY - 1) : 3'd0;

    if ((OUTPUT_NEURON % POST_NEUR_PARALLEL) != 0) begin : g_bad_parallel
        $error("OUTPUT_NEURON must be a multiple of POST_NEUR_PARALLEL");
    end
    if (longint'(DEPTH) > (longint'(1) << SYN_ARRAY_ADDR_WIDTH)) begin : g_bad_depth
        $error("synaptic array depth exceeds SYN_ARRAY_ADDR_WIDTH");
    end
    if ((UPDATE_LATENCY < 0) || (UPDATE_LATENCY > 7)) begin : g_bad_latency
        $error("UPDATE_LATENCY must be in 0..7");
    end

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_WR   = 3'd3,
        ST_FIN  = 3'd4
    } state_e;

    state_e                          state_q, state_d;
    logic [2:0]                      wait_q, wait_d;
    logic [SYN_ARRAY_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [PRE_NEUR_ADDR_WIDTH-1:0]  pre_q, pre_d;
    logic [POST_NEUR_ADDR_WIDTH-1:0] post_q, post_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic                            cs_q, cs_d;
    logic                            we_q, we_d;

    // Next state, counters, and output values decoded from the next state so every output is a flop.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        addr_d  = addr_q;
        pre_d   = pre_q;
        post_d  = post_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        cs_d    = 1'b0;
        we_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.START && bus.IS_TRAIN) begin
                    state_d = ST_RD;
                    addr_d  = '0;
                    pre_d   = '0;
                    post_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                wait_d = 3'd0;
                if (UPDATE_LATENCY == 0) begin
                    state_d = ST_WR;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = ST_WR;
                    wait_d  = 3'd0;
                end else begin
                    wait_d  = wait_q + 3'd1;
                end
            end
            ST_WR: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_FIN;
                    addr_d  = '0;
                    pre_d   = '0;
                    post_d  = '0;
                end else begin
                    state_d = ST_RD;
                    addr_d  = addr_q + ADDR_ONE;
                    // Group is the inner loop: the pre index advances only when the lanes wrap.
                    if (post_q == POST_LAST) begin
                        post_d = '0;
                        pre_d  = pre_q + PRE_ONE;
                    end else begin
                        post_d = post_q + POST_STEP;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                wait_d  = 3'd0;
                addr_d  = '0;
                pre_d   = '0;
                post_d  = '0;
            end
        endcase

        case (state_d)
            ST_RD: begin
                busy_d = 1'b1;
                cs_d   = 1'b1;
            end
            ST_WAIT: begin
                busy_d = 1'b1;
            end
            ST_WR: begin
                busy_d = 1'b1;
                cs_d   = 1'b1;
                we_d   = 1'b1;
            end
            ST_FIN: begin
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // State, counter and output registers; reset aborts a sweep with all SRAM controls low.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= ST_IDLE;
            wait_q  <= 3'd0;
            addr_q  <= '0;
            pre_q   <= '0;
            post_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            addr_q  <= addr_d;
            pre_q   <= pre_d;
            post_q  <= post_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cs_q    <= cs_d;
            we_q    <= we_d;
        end
    end

    assign bus.BUSY                     = busy_q;
    assign bus.DONE                     = done_q;
    assign bus.CTRL_SYNARRAY_CS         = cs_q;
    assign bus.CTRL_SYNARRAY_WE         = we_q;
    assign bus.CTRL_GRAD_ARRAY_CS       = cs_q;
    assign bus.CTRL_GRAD_ARRAY_WE       = we_q;
    assign bus.CTRL_SYNARRAY_ADDR       = addr_q;
    assign bus.CTRL_PRE_NEUR_ADDR       = pre_q;
    assign bus.CTRL_POST_NEURON_ADDRESS = post_q;
endmodule

// File: tb/tb_syn_update_sequencer.sv
// Bench for syn_update_sequencer: three small configurations (latency 0, 2, 1) checked cycle by
// cycle against an arithmetic model of the sweep (word = cycle / period, phase = cycle % period).
module tb_syn_update_sequencer;
    logic       CLK = 1'b0;
    logic       RSTN;
    logic [2:0] start_v;
    logic [2:0] train_v;
    logic [41:0] obs_v [3];

    int cfg_ni  [3] = '{3, 3, 13};
    int cfg_no  [3] = '{8, 8, 24};
    int cfg_lat [3] = '{0, 2, 1};

    localparam logic [41:0] CTRL_MASK = {6'h3F, 36'h0};

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    syn_update_sequencer_if if_a ();
    syn_update_sequencer_if if_b ();
    syn_update_sequencer_if if_c ();

    assign if_a.START = start_v[0];
    assign if_b.START = start_v[1];
    assign if_c.START = start_v[2];
    assign if_a.IS_TRAIN = train_v[0];
    assign if_b.IS_TRAIN = train_v[1];
    assign if_c.IS_TRAIN = train_v[2];

    assign obs_v[0] = {if_a.BUSY, if_a.DONE, if_a.CTRL_SYNARRAY_CS, if_a.CTRL_SYNARRAY_WE,
                       if_a.CTRL_GRAD_ARRAY_CS, if_a.CTRL_GRAD_ARRAY_WE, if_a.CTRL_SYNARRAY_ADDR,
                       if_a.CTRL_PRE_NEUR_ADDR, if_a.CTRL_POST_NEURON_ADDRESS};
    assign obs_v[1] = {if_b.BUSY, if_b.DONE, if_b.CTRL_SYNARRAY_CS, if_b.CTRL_SYNARRAY_WE,
                       if_b.CTRL_GRAD_ARRAY_CS, if_b.CTRL_GRAD_ARRAY_WE, if_b.CTRL_SYNARRAY_ADDR,
                       if_b.CTRL_PRE_NEUR_ADDR, if_b.CTRL_POST_NEURON_ADDRESS};
    assign obs_v[2] = {if_c.BUSY, if_c.DONE, if_c.CTRL_SYNARRAY_CS, if_c.CTRL_SYNARRAY_WE,
                       if_c.CTRL_GRAD_ARRAY_CS, if_c.CTRL_GRAD_ARRAY_WE, if_c.CTRL_SYNARRAY_ADDR,
                       if_c.CTRL_PRE_NEUR_ADDR, if_c.CTRL_POST_NEURON_ADDRESS};

    syn_update_sequencer #(.INPUT_NEURON(3), .OUTPUT_NEURON(8), .POST_NEUR_PARALLEL(4),
                           .UPDATE_LATENCY(0))
        dut_a (.CLK(CLK), .RSTN(RSTN), .bus(if_a.slave));
    syn_update_sequencer #(.INPUT_NEURON(3), .OUTPUT_NEURON(8), .POST_NEUR_PARALLEL(4),
                           .UPDATE_LATENCY(2))
        dut_b (.CLK(CLK), .RSTN(RSTN), .bus(if_b.slave));
    syn_update_sequencer #(.INPUT_NEURON(13), .OUTPUT_NEURON(24), .POST_NEUR_PARALLEL(4),
                           .UPDATE_LATENCY(1))
        dut_c (.CLK(CLK), .RSTN(RSTN), .bus(if_c.slave));

    // {busy, done, syn cs, syn we, grad cs, grad we, addr, pre, post}
    function automatic logic [41:0] pack_exp(input bit busy, input bit done, input bit cs,
                                             input bit we, input int addr, input int pre,
                                             input int post);
        return {busy, done, cs, we, cs, we, 16'(addr), 10'(pre), 10'(post)};
    endfunction

    // One full sweep on instance d; optional START/IS_TRAIN noise; optional reset abort at cycle abort_at.
    task automatic run_sweep(input int d, input string tag, input bit noise, input int abort_at);
        int g, depth, t, w, p;
        logic [41:0] exp_s, msk;
        g     = cfg_no[d] / 4;
        depth = cfg_ni[d] * g;
        t     = 2 + cfg_lat[d];
        start_v[d] = 1'b1;
        train_v[d] = 1'b1;
        for (int k = 0; k <= depth * t; k++) begin
            @(posedge CLK); #1;
            if (k < depth * t) begin
                w = k / t;
                p = k % t;
                exp_s = pack_exp(1'b1, 1'b0, (p == 0) || (p == t - 1), p == t - 1, w, w / g, (w % g) * 4);
                msk   = '1;
            end else begin
                exp_s = pack_exp(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0);
                msk   = CTRL_MASK;
            end
            n_cmp++;
            if ((obs_v[d] & msk) !== (exp_s & msk)) begin
                n_bad++;
                $display("FAIL %s cycle %0d: got %h expected %h", tag, k, obs_v[d] & msk, exp_s & msk);
            end
            if (k == abort_at) begin
                #2;
                RSTN = 1'b0;
                #1;
                n_cmp++;
                if (obs_v[d] !== 42'h0) begin
                    n_bad++;
                    $display("FAIL %s async_reset: got %h expected 0", tag, obs_v[d]);
                end
                @(posedge CLK); #1;
                n_cmp++;
                if (obs_v[d] !== 42'h0) begin
                    n_bad++;
                    $display("FAIL %s reset_hold: got %h expected 0", tag, obs_v[d]);
                end
                RSTN       = 1'b1;
                start_v[d] = 1'b0;
                return;
            end
            start_v[d] = noise ? ((k == 4) || (k == depth * t) || ($urandom_range(0, 3) == 0)) : 1'b0;
            train_v[d] = noise ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        start_v[d] = 1'b0;
        train_v[d] = 1'b1;
    endtask

    // n idle cycles on instance d; with noise, START toggles randomly while IS_TRAIN is low.
    task automatic idle_cycles(input int d, input int n, input string tag, input bit noise);
        for (int i = 0; i < n; i++) begin
            start_v[d] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            train_v[d] = noise ? 1'b0 : 1'b1;
            @(posedge CLK); #1;
            n_cmp++;
            if (obs_v[d] !== 42'h0) begin
                n_bad++;
                $display("FAIL %s idle %0d: got %h expected 0", tag, i, obs_v[d]);
            end
        end
        start_v[d] = 1'b0;
        train_v[d] = 1'b1;
    endtask

    task automatic test_reset();
        RSTN    = 1'b1;
        start_v = 3'b000;
        train_v = 3'b111;
        #2 RSTN = 1'b0;
        @(posedge CLK); @(posedge CLK); #1;
        for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (obs_v[d] !== 42'h0) begin
                n_bad++;
                $display("FAIL reset inst %0d: got %h expected 0", d, obs_v[d]);
            end
        end
        RSTN = 1'b1;
        idle_cycles(0, 2, "reset_idle", 1'b0);
    endtask

    task automatic test_sweep_lat0();
        run_sweep(0, "lat0", 1'b0, -1);
        idle_cycles(0, 3, "lat0_after", 1'b0);
    endtask

    task automatic test_sweep_lat2();
        run_sweep(1, "lat2", 1'b0, -1);
        idle_cycles(1, 3, "lat2_after", 1'b0);
    endtask

    task automatic test_train_low();
        idle_cycles(0, 20, "train_low", 1'b1);
    endtask

    task automatic test_start_ignored();
        run_sweep(0, "start_ignored", 1'b1, -1);
        idle_cycles(0, 4, "start_ignored_after", 1'b0);
    endtask

    task automatic test_reset_abort();
        run_sweep(0, "abort", 1'b0, 7);
        idle_cycles(0, 5, "post_abort", 1'b0);
        run_sweep(0, "restart", 1'b0, -1);
        idle_cycles(0, 2, "restart_after", 1'b0);
    endtask

    task automatic test_back_to_back();
        run_sweep(2, "b2b_first", 1'b0, -1);
        idle_cycles(2, 1, "b2b_gap", 1'b0);
        run_sweep(2, "b2b_second", 1'b1, -1);
        idle_cycles(2, 2, "b2b_after", 1'b0);
    endtask

    task automatic test_random();
        int d;
        for (int r = 0; r < 4; r++) begin
            d = $urandom_range(0, 2);
            idle_cycles(d, $urandom_range(1, 4), "rand_gap", 1'b1);
            run_sweep(d, "rand_sweep", 1'($urandom_range(0, 1)), -1);
            idle_cycles(d, 1, "rand_after", 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_sweep_lat0();
        test_sweep_lat2();
        test_train_low();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
